// File: rtl/nonce_job_scheduler_if.sv
// nonce_job_scheduler_if
//    Bundles the host word stream, the solution handshake and the SHA
//    datapath controls that surround the nonce job scheduler.
//    master : the host / SHA side (drives job stream, responses, core hits)
//    slave  : the scheduler itself (drives shift enables, strobes, status)
//    Signals:
//       start_found, data_valid, in_data[31:0], sol_response[1:0],
//       core_found, core_nonce[31:0]                      -> scheduler
//       sr_clear, mid_shift, head_shift, load_state, solve_en, sol_claim,
//       out_data[31:0], busy, exhausted, nonce_count[31:0] <- scheduler
interface nonce_job_scheduler_if;
   logic        start_found;
   logic        data_valid;
   logic [31:0] in_data;
   logic [1:0]  sol_response;
   logic        core_found;
   logic [31:0] core_nonce;
   logic        sr_clear;
   logic        mid_shift;
   logic        head_shift;
   logic        load_state;
   logic        solve_en;
   logic        sol_claim;
   logic [31:0] out_data;
   logic        busy;
   logic        exhausted;
   logic [31:0] nonce_count;

   modport master (
      output start_found, data_valid, in_data, sol_response, core_found, core_nonce,
      input  sr_clear, mid_shift, head_shift, load_state, solve_en, sol_claim,
      input  out_data, busy, exhausted, nonce_count
   );

   modport slave (
      input  start_found, data_valid, in_data, sol_response, core_found, core_nonce,
      output sr_clear, mid_shift, head_shift, load_state, solve_en, sol_claim,
      output out_data, busy, exhausted, nonce_count
   );
endinterface

// File: rtl/nonce_job_scheduler.sv
// nonce_job_scheduler
//    Sequences one mining job through the SHA datapath. Valid-qualified
//    host words are counted into the midstate (MID_WORDS) and header
//    (HEAD_WORDS) shift registers, the midstate load is strobed once, then
//    the core runs while solve cycles are counted. A core hit is latched and
//    offered to the host as a claim (accept / reject-and-resume / abort);
//    running NONCE_LIMIT cycles without a hit parks the job as exhausted.
//    Ports:
//       clk    : system clock, rising edge
//       n_rst  : synchronous active-low reset
//       bus    : nonce_job_scheduler_if.slave (host stream, claim handshake,
//                shift enables, load strobe, solve enable, status)
module nonce_job_scheduler #(
   parameter int unsigned MID_WORDS   = 8,
   parameter int unsigned HEAD_WORDS  = 16,
   parameter logic [31:0] NONCE_LIMIT = 32'hFFFF_FFFF
) (
   input logic                  clk,
   input logic                  n_rst,
   nonce_job_scheduler_if.slave bus
);

   localparam int unsigned MAX_WORDS = (HEAD_WORDS > MID_WORDS) ? HEAD_WORDS : MID_WORDS;
   localparam int unsigned CNT_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
   localparam logic [CNT_W-1:0] MID_LAST  = CNT_W'(MID_WORDS - 1);
   localparam logic [CNT_W-1:0] HEAD_LAST = CNT_W'(HEAD_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE,
      MID,
      HEAD,
      LOAD,
      SOLVE,
      CLAIM,
      DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] word_cnt;
   logic [CNT_W-1:0] word_cnt_next;
   logic [31:0]      nonce_cnt;
   logic [31:0]      nonce_cnt_next;
   logic [31:0]      nonce_inc;
   logic [31:0]      gold_nonce;
   logic [31:0]      gold_nonce_next;

   // State, word counter, solve counter and golden nonce all live here.
   // Reset drops whatever job was running, including a pending claim,
   // and returns to IDLE with every counter and the latched nonce cleared.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state      <= IDLE;
         word_cnt   <= '0;
         nonce_cnt  <= '0;
         gold_nonce <= '0;
      end else begin
         state      <= state_next;
         word_cnt   <= word_cnt_next;
         nonce_cnt  <= nonce_cnt_next;
         gold_nonce <= gold_nonce_next;
      end
   end

   // The solve counter saturates at NONCE_LIMIT. The job is declared
   // exhausted on the cycle this incremented value reaches the limit, so
   // NONCE_LIMIT solve cycles without a hit lead to DONE.
   always_comb begin
      nonce_inc = (nonce_cnt == NONCE_LIMIT) ? nonce_cnt : nonce_cnt + 32'd1;
   end

   // Next-state logic. start_found overrides everything and restarts framing
   // from any state, abandoning a claim. Word counting only advances on
   // data_valid, so a stalled host simply holds MID or HEAD indefinitely.
   // In SOLVE a core hit beats exhaustion: the nonce is latched and the
   // counter is left frozen so a rejected claim resumes where it stopped.
   always_comb begin
      state_next      = state;
      word_cnt_next   = word_cnt;
      nonce_cnt_next  = nonce_cnt;
      gold_nonce_next = gold_nonce;

      if (bus.start_found) begin
         state_next     = MID;
         word_cnt_next  = '0;
         nonce_cnt_next = '0;
      end else begin
         case (state)
            IDLE: begin
               state_next = IDLE;
            end
            MID: begin
               if (bus.data_valid) begin
                  if (word_cnt == MID_LAST) begin
                     state_next    = HEAD;
                     word_cnt_next = '0;
                  end else begin
                     word_cnt_next = word_cnt + 1'b1;
                  end
               end
            end
            HEAD: begin
               if (bus.data_valid) begin
                  if (word_cnt == HEAD_LAST) begin
                     state_next    = LOAD;
                     word_cnt_next = '0;
                  end else begin
                     word_cnt_next = word_cnt + 1'b1;
                  end
               end
            end
            LOAD: begin
               state_next     = SOLVE;
               nonce_cnt_next = '0;
            end
            SOLVE: begin
               if (bus.core_found) begin
                  state_next      = CLAIM;
                  gold_nonce_next = bus.core_nonce;
               end else begin
                  nonce_cnt_next = nonce_inc;
                  if (nonce_inc == NONCE_LIMIT) begin
                     state_next = DONE;
                  end
               end
            end
            CLAIM: begin
               case (bus.sol_response)
                  2'b01: begin
                     state_next = IDLE;
                  end
                  2'b10: begin
                     state_next = SOLVE;
                  end
                  2'b11: begin
                     state_next      = IDLE;
                     gold_nonce_next = '0;
                  end
                  default: begin
                     state_next = CLAIM;
                  end
               endcase
            end
            DONE: begin
               state_next = DONE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // Outputs decode straight from the state register. The shift enables
   // follow data_valid so only real words move the shift registers, and
   // sr_clear also fires on start_found so a restart clears the datapath
   // in the same cycle the job is re-armed.
   always_comb begin
      bus.sr_clear    = (state == IDLE) | bus.start_found;
      bus.mid_shift   = (state == MID)  & bus.data_valid;
      bus.head_shift  = (state == HEAD) & bus.data_valid;
      bus.load_state  = (state == LOAD);
      bus.solve_en    = (state == SOLVE);
      bus.sol_claim   = (state == CLAIM);
      bus.exhausted   = (state == DONE);
      bus.busy        = (state == MID) | (state == HEAD) | (state == LOAD) |
                        (state == SOLVE) | (state == CLAIM);
      bus.out_data    = gold_nonce;
      bus.nonce_count = nonce_cnt;
   end

endmodule

// File: tb/tb_nonce_job_scheduler.sv
// tb_nonce_job_scheduler
//    Drives nonce_job_scheduler (NONCE_LIMIT shortened to 16) through whole
//    jobs from a table of {inputs, expected outputs} records, then through
//    gapped framing, restarts during HEAD/CLAIM and reset during SOLVE.
module tb_nonce_job_scheduler;

   localparam logic [7:0] SR = 8'h80;
   localparam logic [7:0] MS = 8'h40;
   localparam logic [7:0] HS = 8'h20;
   localparam logic [7:0] LD = 8'h10;
   localparam logic [7:0] SE = 8'h08;
   localparam logic [7:0] SC = 8'h04;
   localparam logic [7:0] BZ = 8'h02;
   localparam logic [7:0] EX = 8'h01;

   typedef struct packed {
      logic [7:0]  ctl;
      logic [31:0] od;
      logic [31:0] nc;
   } exp_t;

   typedef struct packed {
      logic        start;
      logic        valid;
      logic [1:0]  resp;
      logic        found;
      logic [31:0] nonce;
      exp_t        e;
   } vec_t;

   logic clk;
   logic n_rst;
   int   checks;
   int   errors;
   vec_t vecs[$];
   exp_t sbq[$];

   nonce_job_scheduler_if bus ();

   nonce_job_scheduler #(
      .MID_WORDS   (8),
      .HEAD_WORDS  (16),
      .NONCE_LIMIT (32'd16)
   ) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the stimulus ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL timeout: got still-running expected finished");
      $fatal(1, "[TB] timeout");
   end

   function automatic logic [7:0] ctlNow();
      return {bus.sr_clear, bus.mid_shift, bus.head_shift, bus.load_state,
              bus.solve_en, bus.sol_claim, bus.busy, bus.exhausted};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic st, input logic vd, input logic [1:0] rs,
                        input logic fd, input logic [31:0] nn);
      bus.start_found  = st;
      bus.data_valid   = vd;
      bus.in_data      = vd ? $urandom : 32'd0;
      bus.sol_response = rs;
      bus.core_found   = fd;
      bus.core_nonce   = nn;
   endtask

   task automatic addVec(input logic st, input logic vd, input logic [1:0] rs, input logic fd,
                         input logic [31:0] nn, input logic [7:0] ctl,
                         input logic [31:0] od, input logic [31:0] nc);
      vec_t v;
      v.start = st;
      v.valid = vd;
      v.resp  = rs;
      v.found = fd;
      v.nonce = nn;
      v.e.ctl = ctl;
      v.e.od  = od;
      v.e.nc  = nc;
      vecs.push_back(v);
   endtask

   // 8 midstate words, 16 header words, then the load cycle.
   task automatic addFrame(input logic [31:0] od);
      for (int i = 0; i < 8; i++)  addVec(1'b0, 1'b1, 2'b00, 1'b0, 32'd0, MS | BZ, od, 32'd0);
      for (int i = 0; i < 16; i++) addVec(1'b0, 1'b1, 2'b00, 1'b0, 32'd0, HS | BZ, od, 32'd0);
      addVec(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, LD | BZ, od, 32'd0);
   endtask

   task automatic addSolve(input logic [31:0] od, input int from, input int to);
      for (int n = from; n <= to; n++)
         addVec(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, SE | BZ, od, 32'(n));
   endtask

   task automatic applyStimulus(input vec_t v);
      drive(v.start, v.valid, v.resp, v.found, v.nonce);
      sbq.push_back(v.e);
   endtask

   task automatic checkOutput(input int idx);
      exp_t e;
      if (sbq.size() == 0) begin
         check($sformatf("vec%0d scoreboard", idx), 32'd0, 32'd1);
      end else begin
         e = sbq.pop_front();
         check($sformatf("vec%0d ctl", idx), {24'd0, ctlNow()}, {24'd0, e.ctl});
         check($sformatf("vec%0d out_data", idx), bus.out_data, e.od);
         check($sformatf("vec%0d nonce_count", idx), bus.nonce_count, e.nc);
      end
   endtask

   initial begin
      int mid_pulses;
      int cnt;
      logic head_seen;
      logic reached;

      checks = 0;
      errors = 0;
      n_rst  = 1'b0;
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0);

      // Reset state
      tick();
      tick();
      check("reset ctl", {24'd0, ctlNow()}, {24'd0, SR});
      check("reset out_data", bus.out_data, 32'd0);
      check("reset nonce_count", bus.nonce_count, 32'd0);
      n_rst = 1'b1;

      // Job 1: full framing, hit DEADBEEF at count 5, hold, accept
      addVec(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, SR, 32'd0, 32'd0);
      addVec(1'b1, 1'b0, 2'b00, 1'b0, 32'd0, SR, 32'd0, 32'd0);
      addFrame(32'd0);
      addSolve(32'd0, 0, 4);
      addVec(1'b0, 1'b0, 2'b00, 1'b1, 32'hDEAD_BEEF, SE | BZ, 32'd0, 32'd5);
      addVec(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, SC | BZ, 32'hDEAD_BEEF, 32'd5);
      addVec(1'b0, 1'b0, 2'b01, 1'b0, 32'd0, SC | BZ, 32'hDEAD_BEEF, 32'd5);
      addVec(1'b0, 1'b0, 2'b00, 1'b1, 32'h1111_1111, SR, 32'hDEAD_BEEF, 32'd5);

      // Job 2: hit, reject and resume, second hit, abort clears nonce
      addVec(1'b1, 1'b0, 2'b00, 1'b0, 32'd0, SR, 32'hDEAD_BEEF, 32'd5);
      addFrame(32'hDEAD_BEEF);
      addSolve(32'hDEAD_BEEF, 0, 2);
      addVec(1'b0, 1'b0, 2'b00, 1'b1, 32'h1234_5678, SE | BZ, 32'hDEAD_BEEF, 32'd3);
      addVec(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, SC | BZ, 32'h1234_5678, 32'd3);
      addSolve(32'h1234_5678, 3, 4);
      addVec(1'b0, 1'b0, 2'b00, 1'b1, 32'hCAFE_F00D, SE | BZ, 32'h1234_5678, 32'd5);
      addVec(1'b0, 1'b0, 2'b11, 1'b0, 32'd0, SC | BZ, 32'hCAFE_F00D, 32'd5);
      addVec(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, SR, 32'd0, 32'd5);

      // Job 3: no hit, exhausts after 16 solve cycles; stray response ignored
      addVec(1'b1, 1'b0, 2'b00, 1'b0, 32'd0, SR, 32'd0, 32'd5);
      addFrame(32'd0);
      addSolve(32'd0, 0, 1);
      addVec(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, SE | BZ, 32'd0, 32'd2);
      addSolve(32'd0, 3, 15);
      addVec(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, EX, 32'd0, 32'd16);
      addVec(1'b0, 1'b0, 2'b01, 1'b1, 32'hFFFF_0000, EX, 32'd0, 32'd16);
      addVec(1'b0, 1'b1, 2'b00, 1'b0, 32'd0, EX, 32'd0, 32'd16);
      addVec(1'b1, 1'b0, 2'b00, 1'b0, 32'd0, SR | EX, 32'd0, 32'd16);

      // Job 4: hit on the very cycle the count would reach the limit
      addFrame(32'd0);
      addSolve(32'd0, 0, 14);
      addVec(1'b0, 1'b0, 2'b00, 1'b1, 32'h0000_0F0F, SE | BZ, 32'd0, 32'd15);
      addVec(1'b0, 1'b0, 2'b01, 1'b0, 32'd0, SC | BZ, 32'h0000_0F0F, 32'd15);
      addVec(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, SR, 32'h0000_0F0F, 32'd15);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         #1;
         checkOutput(i);
         tick();
      end
      check("scoreboard drained", 32'(sbq.size()), 32'd0);

      // Gapped data_valid during MID
      drive(1'b1, 1'b0, 2'b00, 1'b0, 32'd0);
      #1;
      check("gap start sr_clear", {31'd0, bus.sr_clear}, 32'd1);
      tick();
      mid_pulses = 0;
      head_seen  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, (i % 2) == 0, 2'b00, 1'b0, 32'd0);
         #1;
         if (bus.mid_shift)  mid_pulses++;
         if (bus.head_shift) head_seen = 1'b1;
         tick();
      end
      check("gap mid pulses", 32'(mid_pulses), 32'd8);
      check("gap head early", {31'd0, head_seen}, 32'd0);
      drive(1'b0, 1'b1, 2'b00, 1'b0, 32'd0);
      #1;
      check("gap head starts", {30'd0, bus.mid_shift, bus.head_shift}, 32'd1);
      tick();

      // Restart during HEAD: framing starts over from word 0
      drive(1'b1, 1'b1, 2'b00, 1'b0, 32'd0);
      #1;
      check("head restart sr_clear", {31'd0, bus.sr_clear}, 32'd1);
      tick();
      cnt     = 0;
      reached = 1'b0;
      for (int i = 0; i < 20 && !reached; i++) begin
         drive(1'b0, 1'b1, 2'b00, 1'b0, 32'd0);
         #1;
         if (bus.head_shift) reached = 1'b1;
         else if (bus.mid_shift) cnt++;
         tick();
      end
      check("head restart reached head", {31'd0, reached}, 32'd1);
      check("head restart mid words", 32'(cnt), 32'd8);
      for (int i = 0; i < 15; i++) begin
         drive(1'b0, 1'b1, 2'b00, 1'b0, 32'd0);
         tick();
      end
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0);
      #1;
      check("restart load_state", {31'd0, bus.load_state}, 32'd1);
      tick();
      drive(1'b0, 1'b0, 2'b00, 1'b1, 32'hA5A5_A5A5);
      #1;
      check("restart solve_en", {31'd0, bus.solve_en}, 32'd1);
      tick();

      // Restart during CLAIM: claim dropped, back in MID
      drive(1'b1, 1'b0, 2'b00, 1'b0, 32'd0);
      #1;
      check("claim restart ctl", {24'd0, ctlNow()}, {24'd0, SR | SC | BZ});
      tick();
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0);
      #1;
      check("claim dropped ctl", {24'd0, ctlNow()}, {24'd0, BZ});
      check("claim dropped nonce_count", bus.nonce_count, 32'd0);
      check("claim dropped out_data", bus.out_data, 32'hA5A5_A5A5);

      // Reset during SOLVE
      for (int i = 0; i < 24; i++) begin
         drive(1'b0, 1'b1, 2'b00, 1'b0, 32'd0);
         tick();
      end
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0);
      tick();
      tick();
      check("pre-reset solve_en", {31'd0, bus.solve_en}, 32'd1);
      check("pre-reset nonce_count", bus.nonce_count, 32'd1);
      n_rst = 1'b0;
      tick();
      check("mid-job reset ctl", {24'd0, ctlNow()}, {24'd0, SR});
      check("mid-job reset out_data", bus.out_data, 32'd0);
      check("mid-job reset nonce_count", bus.nonce_count, 32'd0);
      n_rst = 1'b1;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
